// File: rtl/npu_bus_rx.sv
// Host-bus receiver/transmitter for the NPU: decodes the we-qualified word stream into
// config, weight and input writes, launches the core, and returns results under oe.
// Optional feature macro: NPU_RX_ERR_EN (sticky protocol error reporting).
module npu_bus_rx #(
    parameter int FIFO_AW = 5,
    parameter int WGT_AW  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic               oe,
    input  logic [31:0]        data_i,
    output logic [31:0]        data_o,
    output logic               data_t,
    output logic               ready,
    output logic [1:0]         num_layers,
    output logic [4:0]         num_in,
    output logic [4:0]         num_h1,
    output logic [4:0]         num_h2,
    output logic [4:0]         num_out,
    output logic               act,
    output logic               wgt_we,
    output logic [WGT_AW-1:0]  wgt_addr,
    output logic [31:0]        wgt_data,
    output logic               in_we,
    output logic [FIFO_AW-1:0] in_addr,
    output logic [31:0]        in_data,
    output logic               start,
    input  logic               done,
    output logic [FIFO_AW-1:0] res_addr,
    input  logic [31:0]        res_data,
    output logic               err
);

    typedef enum logic [2:0] {IDLE, HDR, WGT, INP, BUSY, OUT} state_t;

    state_t               state, state_n;
    logic [2:0]           hdr_cnt;
    logic [WGT_AW-1:0]    cnt;
    logic [WGT_AW-1:0]    w_last;
    logic [WGT_AW-1:0]    w_calc;
    logic [FIFO_AW-1:0]   rd_idx;
    logic                 err_q;

    // Weights for one layer pair: (src neurons + bias) * dst neurons, counts stored minus-one.
    function automatic logic [WGT_AW-1:0] pair_w(input logic [4:0] a, input logic [4:0] b);
        return (WGT_AW'(a) + WGT_AW'(2)) * (WGT_AW'(b) + WGT_AW'(1));
    endfunction

`ifdef NPU_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
    logic abort;
    assign abort = ((state == HDR || state == WGT || state == INP) && !we)
                 || (state == HDR && we && hdr_cnt == 3'd0 && data_i[1:0] == 2'd3)
                 || (state == BUSY && we);
    always_ff @(posedge clk) begin
        if (rst)        err_q <= 1'b0;
        else if (abort) err_q <= 1'b1;
    end
`else
    localparam bit ERR_EN = 1'b0;
    assign err_q = 1'b0;
`endif

    assign err      = err_q;
    assign ready    = (state == IDLE) || (state == OUT);
    assign res_addr = rd_idx;
    assign data_o   = (state == OUT) ? res_data : 32'd0;
    assign data_t   = (state == OUT) && oe && !we;

    always_comb begin
        unique case (num_layers)
            2'd0:    w_calc = pair_w(num_in, num_out);
            2'd1:    w_calc = pair_w(num_in, num_h1) + pair_w(num_h1, num_out);
            default: w_calc = pair_w(num_in, num_h1) + pair_w(num_h1, num_h2) + pair_w(num_h2, num_out);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (we && !err_q) state_n = HDR;
            HDR: begin
                if (!we)                                                  state_n = IDLE;
                else if (ERR_EN && hdr_cnt == 3'd0 && data_i[1:0] == 2'd3) state_n = IDLE;
                else if (hdr_cnt == 3'd5)                                 state_n = WGT;
            end
            WGT: begin
                if (!we)                 state_n = IDLE;
                else if (cnt == w_last)  state_n = INP;
            end
            INP: begin
                if (!we)                           state_n = IDLE;
                else if (cnt == WGT_AW'(num_in))   state_n = BUSY;
            end
            BUSY: begin
                if (ERR_EN && we) state_n = IDLE;
                else if (done)    state_n = OUT;
            end
            OUT: begin
                // A write here is the preamble of the next stream; pending results are dropped.
                if (we)                                         state_n = err_q ? IDLE : HDR;
                else if (oe && rd_idx == FIFO_AW'(num_out))     state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_cnt    <= '0;
            cnt        <= '0;
            w_last     <= '0;
            rd_idx     <= '0;
            num_layers <= '0;
            num_in     <= '0;
            num_h1     <= '0;
            num_h2     <= '0;
            num_out    <= '0;
            act        <= 1'b0;
            wgt_we     <= 1'b0;
            wgt_addr   <= '0;
            wgt_data   <= '0;
            in_we      <= 1'b0;
            in_addr    <= '0;
            in_data    <= '0;
            start      <= 1'b0;
        end else begin
            wgt_we  <= 1'b0;
            in_we   <= 1'b0;
            start   <= 1'b0;
            hdr_cnt <= (state == HDR) ? hdr_cnt + 3'd1 : 3'd0;
            cnt     <= (state_n != state || !(state == WGT || state == INP)) ? '0 : cnt + WGT_AW'(1);
            if (state == OUT) begin
                if (oe && !we) rd_idx <= rd_idx + FIFO_AW'(1);
            end else begin
                rd_idx <= '0;
            end

            if (state == HDR && we) begin
                case (hdr_cnt)
                    3'd0: num_layers <= (!ERR_EN && data_i[1:0] == 2'd3) ? 2'd2 : data_i[1:0];
                    3'd1: num_in     <= data_i[4:0];
                    3'd2: num_h1     <= data_i[4:0];
                    3'd3: num_h2     <= data_i[4:0];
                    3'd4: num_out    <= data_i[4:0];
                    3'd5: begin
                        act    <= data_i[0];
                        w_last <= w_calc - WGT_AW'(1);
                    end
                    default: ;
                endcase
            end

            if (state == WGT && we) begin
                wgt_we   <= 1'b1;
                wgt_addr <= cnt;
                wgt_data <= data_i;
            end

            if (state == INP && we) begin
                in_we   <= 1'b1;
                in_addr <= cnt[FIFO_AW-1:0];
                in_data <= data_i;
                start   <= (cnt == WGT_AW'(num_in));
            end
        end
    end

endmodule

// File: tb/tb_npu_bus_rx.sv
// Directed scoreboard bench for npu_bus_rx: write expectations are queued as words are
// driven and popped by a monitor when the registered write strobes appear.
module tb_npu_bus_rx;

    localparam int FIFO_AW = 5;
    localparam int WGT_AW  = 12;
`ifdef NPU_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [31:0] PREAMBLE = 32'hA5A5_0003;

    logic               clk = 1'b0;
    logic               rst, we, oe, done;
    logic [31:0]        data_i, data_o, res_data;
    logic               data_t, ready, act, wgt_we, in_we, start, err;
    logic [1:0]         num_layers;
    logic [4:0]         num_in, num_h1, num_h2, num_out;
    logic [WGT_AW-1:0]  wgt_addr;
    logic [31:0]        wgt_data, in_data;
    logic [FIFO_AW-1:0] in_addr, res_addr;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         wq[$];
    wr_t         iq[$];
    logic [31:0] sq[$];
    wr_t         w_e, i_e;
    int          n_chk = 0, n_fail = 0, n_start = 0, exp_starts = 0;
    logic [31:0] res_mem [2] = '{32'h1111_1111, 32'h2222_2222};
    logic [31:0] tbl [6] = '{32'h3F80_0000, 32'h3FC0_0000, 32'h4000_0000,
                             32'h4020_0000, 32'h4040_0000, 32'h40A0_0000};

    always #5 clk = ~clk;

    always_comb res_data = (res_addr < 2) ? res_mem[res_addr[0]] : 32'hBAD0_BAD0;

    npu_bus_rx #(.FIFO_AW(FIFO_AW), .WGT_AW(WGT_AW)) dut (
        .clk(clk), .rst(rst), .we(we), .oe(oe), .data_i(data_i), .data_o(data_o),
        .data_t(data_t), .ready(ready), .num_layers(num_layers), .num_in(num_in),
        .num_h1(num_h1), .num_h2(num_h2), .num_out(num_out), .act(act),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .in_we(in_we), .in_addr(in_addr), .in_data(in_data), .start(start),
        .done(done), .res_addr(res_addr), .res_data(res_data), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: registered strobes are stable at the falling edge.
    always @(negedge clk) begin
        if (wgt_we) begin
            if (wq.size() == 0) chk("wgt_unexpected", 32'd1, 32'd0);
            else begin
                w_e = wq.pop_front();
                chk("wgt_addr", 32'(wgt_addr), w_e.addr);
                chk("wgt_data", wgt_data, w_e.data);
            end
        end
        if (in_we) begin
            if (iq.size() == 0) chk("in_unexpected", 32'd1, 32'd0);
            else begin
                i_e = iq.pop_front();
                chk("in_addr", 32'(in_addr), i_e.addr);
                chk("in_data", in_data, i_e.data);
            end
        end
        if (start) begin
            n_start++;
            chk("start_in_we", 32'(in_we), 32'd1);
            if (sq.size() == 0) chk("start_unexpected", 32'd1, 32'd0);
            else chk("start_addr", 32'(in_addr), sq.pop_front());
        end
    end

    function automatic int wcount(input int h[6]);
        int s[4];
        int n, w;
        s[0] = h[1];
        n = 1;
        if (h[0] >= 1) begin s[n] = h[2]; n = n + 1; end
        if (h[0] >= 2) begin s[n] = h[3]; n = n + 1; end
        s[n] = h[4];
        n = n + 1;
        w = 0;
        for (int i = 0; i < n - 1; i++) w += (s[i] + 2) * (s[i+1] + 1);
        return w;
    endfunction

    task automatic put(input logic [31:0] d);
        @(negedge clk);
        we = 1'b1;
        data_i = d;
    endtask

    task automatic reset_chk();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_wgt_we", 32'(wgt_we), 32'd0);
        chk("rst_in_we", 32'(in_we), 32'd0);
        chk("rst_data_t", 32'(data_t), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cfg", {14'd0, act, num_layers, num_in, num_h1, num_h2, num_out}, 32'd0);
        chk("rst_addrs", {3'd0, wgt_addr, in_addr, res_addr}, 32'd0);
        chk("rst_data_o", data_o, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; we = 1'b0; oe = 1'b0;
        @(negedge clk);
        #1 reset_chk();
        rst = 1'b0;
    endtask

    task automatic send_body(input int h[6], input bit acc, output int w);
        logic [31:0] d;
        wr_t e;
        for (int i = 0; i < 6; i++) put(32'(h[i]));
        w = wcount(h);
        for (int k = 0; k < w; k++) begin
            d = (k < 6) ? tbl[k] : $urandom;
            e.addr = 32'(k); e.data = d;
            if (acc) wq.push_back(e);
            put(d);
            if (k == 0) begin
                oe = 1'b1;
                #1 chk("load_data_t", 32'(data_t), 32'd0);
                oe = 1'b0;
            end
        end
        for (int k = 0; k <= h[1]; k++) begin
            d = $urandom;
            e.addr = 32'(k); e.data = d;
            if (acc) begin
                iq.push_back(e);
                if (k == h[1]) sq.push_back(32'(k));
            end
            put(d);
        end
    endtask

    task automatic send_stream(input int h[6], input bit acc, output int w);
        put(PREAMBLE);
        send_body(h, acc, w);
    endtask

    task automatic readout(input int n, input bit fin);
        @(negedge clk);
        we = 1'b0; oe = 1'b1;
        #1;
        chk("busy_ready", 32'(ready), 32'd0);
        chk("busy_data_t", 32'(data_t), 32'd0);
        chk("q_empty", 32'(wq.size() + iq.size() + sq.size()), 32'd0);
        chk("starts", 32'(n_start), 32'(exp_starts));
        done = 1'b1; oe = 1'b0;
        @(negedge clk);
        done = 1'b0;
        #1;
        chk("out_noe_data_t", 32'(data_t), 32'd0);
        chk("out_ready", 32'(ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            oe = 1'b1;
            #1;
            chk("rd_data", data_o, res_mem[i]);
            chk("rd_addr", 32'(res_addr), 32'(i));
            chk("rd_data_t", 32'(data_t), 32'd1);
            chk("rd_ready", 32'(ready), 32'd1);
            @(negedge clk);
        end
        if (fin) begin
            oe = 1'b1;
            #1;
            chk("idle_data_t", 32'(data_t), 32'd0);
            chk("idle_data_o", data_o, 32'd0);
            chk("idle_ready", 32'(ready), 32'd1);
            @(negedge clk);
            oe = 1'b0;
        end
    endtask

    initial begin
        int hdr[6];
        int w;
        logic [31:0] d;
        wr_t e;
        rst = 1'b1; we = 1'b0; oe = 1'b0; done = 1'b0; data_i = '0;
        @(negedge clk);
        #1 reset_chk();
        rst = 1'b0;

        // 2-in / 2-out stream and readout
        hdr = '{0, 1, 0, 0, 1, 0};
        send_stream(hdr, 1'b1, w);
        chk("w_2in2out", 32'(w), 32'd6);
        exp_starts++;
        #1 chk("cfg_in_out", {num_layers, num_in, num_out}, {2'd0, 5'd1, 5'd1});
        readout(2, 1'b1);

        // two hidden layers
        hdr = '{2, 1, 3, 3, 1, 0};
        send_stream(hdr, 1'b1, w);
        chk("w_2hidden", 32'(w), 32'd42);
        exp_starts++;
        #1 chk("cfg_hidden", {num_layers, num_h1, num_h2}, {2'd2, 5'd3, 5'd3});
        readout(2, 1'b1);

        // abort after the 3rd weight
        hdr = '{0, 1, 0, 0, 1, 0};
        put(PREAMBLE);
        for (int i = 0; i < 6; i++) put(32'(hdr[i]));
        for (int k = 0; k < 3; k++) begin
            d = $urandom;
            e.addr = 32'(k); e.data = d;
            wq.push_back(e);
            put(d);
        end
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_err", 32'(err), 32'(ERR_EN));
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_starts", 32'(n_start), 32'(exp_starts));
        chk("abort_q", 32'(wq.size()), 32'd0);
        send_stream(hdr, !ERR_EN, w);
        if (!ERR_EN) exp_starts++;
        @(negedge clk);
        we = 1'b0;
        #1;
        chk("post_abort_starts", 32'(n_start), 32'(exp_starts));
        chk("post_abort_q", 32'(wq.size() + iq.size() + sq.size()), 32'd0);
        chk("post_abort_ready", 32'(ready), 32'(ERR_EN));
        do_reset();

        // reset in the middle of WGT
        put(PREAMBLE);
        for (int i = 0; i < 6; i++) put(32'(hdr[i]));
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            e.addr = 32'(k); e.data = d;
            wq.push_back(e);
            put(d);
        end
        @(negedge clk);
        rst = 1'b1; data_i = 32'hDEAD_BEEF;
        @(negedge clk);
        #1 reset_chk();
        chk("mid_rst_q", 32'(wq.size()), 32'd0);
        rst = 1'b0; we = 1'b0;

        // back-to-back: new preamble in OUT after one of two reads, with oe also high
        send_stream(hdr, 1'b1, w);
        exp_starts++;
        readout(1, 1'b0);
        we = 1'b1; data_i = PREAMBLE;
        #1 chk("both_data_t", 32'(data_t), 32'd0);
        oe = 1'b0;
        hdr = '{0, 0, 0, 0, 0, 1};
        send_body(hdr, 1'b1, w);
        chk("w_min", 32'(w), 32'd2);
        exp_starts++;
        #1 chk("cfg_b2b", {act, num_in, num_out}, {1'b1, 5'd0, 5'd0});
        readout(1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
